// File: rtl/bus_sequencer.sv
// Control sequencer for a four-register shared-bus datapath: MOVE, SWAP (via temp) and LOAD.
// Moore FSM; every enable decodes from the current state and the command latched at Start.
module bus_sequencer (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic [1:0] Op,
   input  logic [1:0] Src,
   input  logic [1:0] Dst,
   output logic [3:0] Rin,
   output logic [3:0] Rout,
   output logic       Tin,
   output logic       Tout,
   output logic       Extern,
   output logic       Busy,
   output logic       Done,
   output logic       Err
);

   typedef enum logic [1:0] {
      OP_MOVE = 2'b00,
      OP_SWAP = 2'b01,
      OP_LOAD = 2'b10,
      OP_BAD  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE,
      MOVE,
      LOAD,
      SW1,
      SW2,
      SW3,
      FIN
   } state_t;

   state_t     state;
   state_t     state_next;
   op_t        op_q;
   logic [1:0] src_q;
   logic [1:0] dst_q;
   logic [3:0] src_sel;
   logic [3:0] dst_sel;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
         op_q  <= OP_MOVE;
         src_q <= 2'b00;
         dst_q <= 2'b00;
      end else begin
         state <= state_next;
         if (state == IDLE && Start) begin
            op_q  <= op_t'(Op);
            src_q <= Src;
            dst_q <= Dst;
         end
      end
   end

   // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (Start) begin
               case (op_t'(Op))
                  OP_MOVE: state_next = MOVE;
                  OP_LOAD: state_next = LOAD;
                  OP_SWAP: state_next = (Src != Dst) ? SW1 : FIN;
                  default: state_next = FIN;
               endcase
            end
         end
         MOVE:    state_next = FIN;
         LOAD:    state_next = FIN;
         SW1:     state_next = SW2;
         SW2:     state_next = SW3;
         SW3:     state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign src_sel = 4'b0001 << src_q;
   assign dst_sel = 4'b0001 << dst_q;

   // Exactly one bus driver per transfer state; IDLE and FIN leave the bus undriven.
   always_comb begin
      Rin    = 4'b0000;
      Rout   = 4'b0000;
      Tin    = 1'b0;
      Tout   = 1'b0;
      Extern = 1'b0;
      Busy   = (state != IDLE);
      Done   = 1'b0;
      Err    = 1'b0;
      case (state)
         MOVE: begin
            Rout = src_sel;
            Rin  = dst_sel;
         end
         LOAD: begin
            Extern = 1'b1;
            Rin    = dst_sel;
         end
         SW1: begin
            Rout = src_sel;
            Tin  = 1'b1;
         end
         SW2: begin
            Rout = dst_sel;
            Rin  = src_sel;
         end
         SW3: begin
            Tout = 1'b1;
            Rin  = dst_sel;
         end
         FIN: begin
            Done = 1'b1;
            Err  = (op_q == OP_BAD);
         end
         default: ;
      endcase
   end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 The block SHALL have port Clock, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-002 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port Start, input, 1 bit: command request, sampled only while Busy=0.
REQ-004 The block SHALL have port Op, input, 2 bits: 00 MOVE, 01 SWAP, 10 LOAD (external data onto the bus), 11 invalid.
REQ-005 The block SHALL have port Src, input, 2 bits: source register index R0..R3, ignored for LOAD.
REQ-006 The block SHALL have port Dst, input, 2 bits: destination register index R0..R3.
REQ-007 The block SHALL have port Rin, output, 4 bits: load enables for R0..R3.
REQ-008 The block SHALL have port Rout, output, 4 bits: tri-state bus drive enables for R0..R3.
REQ-009 The block SHALL have port Tin, output, 1 bit: load enable for the temp register.
REQ-010 The block SHALL have port Tout, output, 1 bit: bus drive enable for the temp register.
REQ-011 The block SHALL have port Extern, output, 1 bit: bus drive enable for external data.
REQ-012 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port Err, output, 1 bit: one-cycle pulse, coincident with Done, for an invalid Op.

Function
REQ-015 The block SHALL be a Moore FSM with states IDLE, MOVE, LOAD, SW1, SW2, SW3, FIN; all outputs SHALL decode from the state and the latched command only.
REQ-016 In IDLE with Start=1, the block SHALL latch Op/Src/Dst at the clock edge; with Start=0 it SHALL stay in IDLE; Start while Busy=1 SHALL be ignored and not queued.
REQ-017 The next state from IDLE SHALL be: MOVE for Op=00; LOAD for Op=10; SW1 for Op=01 with Src!=Dst; FIN with no enables for Op=01 with Src==Dst (no-op); FIN with Err for Op=11.
REQ-018 MOVE SHALL assert Rout[Src] and Rin[Dst], then go to FIN; Src==Dst is legal.
REQ-019 LOAD SHALL assert Extern and Rin[Dst], then go to FIN.
REQ-020 SWAP SHALL sequence as: SW1 asserts Rout[Src] and Tin; SW2 asserts Rout[Dst] and Rin[Src]; SW3 asserts Tout and Rin[Dst]; then FIN.
REQ-021 FIN SHALL assert Done for exactly one cycle (Err too if latched Op=11), with all enables 0, then return to IDLE.
REQ-022 At most one of Rout[3:0], Tout and Extern SHALL be high in any cycle (bus contention rule), and all of them SHALL be 0 in IDLE and FIN.
REQ-023 Latency from the Start-sampling edge SHALL be: MOVE/LOAD, Done in the 2nd cycle; SWAP, Done in the 4th cycle; no-op SWAP or invalid Op, Done in the 1st cycle.
REQ-024 A new Start SHALL be accepted in the first IDLE cycle after FIN (back-to-back throughput).

Reset
REQ-025 Reset=1 at a clock edge SHALL force IDLE from any state, including mid-SWAP, taking priority over Start.
REQ-026 Reset SHALL clear the latched command to 0.
REQ-027 After Reset, Rin, Rout, Tin, Tout, Extern, Busy, Done and Err SHALL all be 0.
REQ-028 An interrupted SWAP SHALL NOT resume after reset.

Verification
REQ-029 The bench SHALL cover MOVE: Start, Op=00, Src=2, Dst=1 -> next cycle Rout=0100, Rin=0010; following cycle Done=1; then Busy=0.
REQ-030 The bench SHALL cover SWAP: Op=01, Src=0, Dst=3 -> (Rout=0001, Tin), then (Rout=1000, Rin=0001), then (Tout, Rin=1000), then Done; with register models the contents are exchanged.
REQ-031 The bench SHALL cover edge commands: SWAP with Src=Dst=2 -> Done next cycle, no enables; Op=11 -> Done=Err=1 next cycle, no enables.
REQ-032 The bench SHALL cover LOAD: Op=10, Dst=3 -> Extern=1, Rin=1000 for one cycle, then Done.
REQ-033 The bench SHALL cover reset mid-operation: Reset=1 during SW2 -> next cycle IDLE, all outputs 0, and Start held high through Busy ignored until IDLE.
REQ-034 The bench SHALL check REQ-022 bus exclusivity every cycle over 1000 random commands.
